// File: rtl/vga_timing_if.sv
// Bundle of score-write inputs and timing/score outputs of the VGA timing generator.
//   master : the timing generator (takes the score writes, drives the timing and scores)
//   slave  : the consumer (pixel generator or bench); it drives the score writes
interface vga_timing_if;
  logic       score_we;     // single-cycle score write strobe
  logic [3:0] score0_in;    // right digit, legal 0..9
  logic [3:0] score1_in;    // left digit, legal 0..9
  logic [9:0] h_cnt;        // current pixel column
  logic [9:0] v_cnt;        // current line
  logic       valid;        // inside the visible area
  logic       hsync;        // active-low horizontal sync
  logic       vsync;        // active-low vertical sync
  logic [3:0] score0;       // frame-stable right digit
  logic [3:0] score1;       // frame-stable left digit
  logic       pix_en;       // one-clk pulse per pixel
  logic       frame_start;  // one-clk pulse when counters become (0,0)
  logic [7:0] frame_cnt;    // frames since reset, wraps

  modport master (
    input  score_we, score0_in, score1_in,
    output h_cnt, v_cnt, valid, hsync, vsync, score0, score1, pix_en, frame_start, frame_cnt
  );

  modport slave (
    output score_we, score0_in, score1_in,
    input  h_cnt, v_cnt, valid, hsync, vsync, score0, score1, pix_en, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with frame-synchronous score staging.
// Divides clk by CLK_DIV to the pixel rate, walks h_cnt/v_cnt over the full raster and
// registers valid/hsync/vsync alongside the counters. Score writes land in pending
// registers and reach score0/score1 only on the frame-boundary edge.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : vga_timing_if.master (score write inputs; timing, score and pulse outputs)
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input logic         clk,
  input logic         rst_n,
  vga_timing_if.master bus
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C   = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [3:0] SCORE_MAX = 4'd9;

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_valid;
  logic             r_hsync;
  logic             r_vsync;
  logic [3:0]       r_pend0;
  logic [3:0]       r_pend1;
  logic [3:0]       r_score0;
  logic [3:0]       r_score1;
  logic             r_pix_en;
  logic             r_frame_start;
  logic [7:0]       r_frame_cnt;

  logic       w_adv;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_frame;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic [3:0] w_pend0_nxt;
  logic [3:0] w_pend1_nxt;

  always_comb begin
    w_adv    = (r_div_cnt == DIV_LAST);
    w_h_last = (r_h_cnt == H_LAST);
    w_v_last = (r_v_cnt == V_LAST);
    w_frame  = w_adv && w_h_last && w_v_last;

    w_h_nxt = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
    w_v_nxt = r_v_cnt;
    if (w_h_last) begin
      w_v_nxt = w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    end

    // Out-of-range digits are dropped per digit; the other digit still loads.
    w_pend0_nxt = r_pend0;
    w_pend1_nxt = r_pend1;
    if (bus.score_we) begin
      if (bus.score0_in <= SCORE_MAX) w_pend0_nxt = bus.score0_in;
      if (bus.score1_in <= SCORE_MAX) w_pend1_nxt = bus.score1_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_valid       <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_pend0       <= '0;
      r_pend1       <= '0;
      r_score0      <= '0;
      r_score1      <= '0;
      r_pix_en      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_pix_en      <= w_adv;
      r_frame_start <= w_frame;
      r_pend0       <= w_pend0_nxt;
      r_pend1       <= w_pend1_nxt;

      if (w_adv) begin
        r_div_cnt <= '0;
        r_h_cnt   <= w_h_nxt;
        r_v_cnt   <= w_v_nxt;
        // Decoded from the new counter values so they line up with h_cnt/v_cnt.
        r_valid   <= (w_h_nxt < H_VIS_C) && (w_v_nxt < V_VIS_C);
        r_hsync   <= !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
        r_vsync   <= !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      // Next-pending values are used so a write on the boundary edge bypasses straight out.
      if (w_frame) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_score0    <= w_pend0_nxt;
        r_score1    <= w_pend1_nxt;
      end
    end
  end

  assign bus.h_cnt       = r_h_cnt;
  assign bus.v_cnt       = r_v_cnt;
  assign bus.valid       = r_valid;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.score0      = r_score0;
  assign bus.score1      = r_score1;
  assign bus.pix_en      = r_pix_en;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (8x6 pixels, CLK_DIV=4) so that
// 256 frames fit in a short run. The reference model derives the raster position from
// the number of clock edges since reset release with plain division/modulo.
module tb_vga_timing_gen;

  localparam int DIV = 4;
  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int FRAME_EDGES = TOT * DIV;

  logic clk;
  logic rst_n;
  vga_timing_if bus ();

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;  // rising edges since reset release

  // Reference model state
  logic [3:0] m_p0, m_p1, m_s0, m_s1;
  int m_h, m_v, m_fc;
  logic m_valid, m_hs, m_vs, m_pe, m_fs;

  typedef struct {
    int         n;
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       pe;
    logic       fs;
    logic [7:0] fc;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic chk_model();
    chk("h_cnt", 32'(bus.h_cnt), 32'(m_h));
    chk("v_cnt", 32'(bus.v_cnt), 32'(m_v));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("hsync", 32'(bus.hsync), 32'(m_hs));
    chk("vsync", 32'(bus.vsync), 32'(m_vs));
    chk("pix_en", 32'(bus.pix_en), 32'(m_pe));
    chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fc));
    chk("score0", 32'(bus.score0), 32'(m_s0));
    chk("score1", 32'(bus.score1), 32'(m_s1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " h_cnt"}, 32'(bus.h_cnt), 0);
    chk({tag, " v_cnt"}, 32'(bus.v_cnt), 0);
    chk({tag, " valid"}, 32'(bus.valid), 0);
    chk({tag, " hsync"}, 32'(bus.hsync), 1);
    chk({tag, " vsync"}, 32'(bus.vsync), 1);
    chk({tag, " score0"}, 32'(bus.score0), 0);
    chk({tag, " score1"}, 32'(bus.score1), 0);
    chk({tag, " pix_en"}, 32'(bus.pix_en), 0);
    chk({tag, " frame_start"}, 32'(bus.frame_start), 0);
    chk({tag, " frame_cnt"}, 32'(bus.frame_cnt), 0);
  endtask

  // Drive inputs, take one rising edge, advance the model and compare everything.
  task automatic step(input logic we, input logic [3:0] s0, input logic [3:0] s1);
    int a, p;
    logic adv, bnd;
    bus.score_we  = we;
    bus.score0_in = s0;
    bus.score1_in = s1;
    @(posedge clk);
    n++;
    adv = (n % DIV == 0);
    a   = n / DIV;
    p   = a % TOT;
    bnd = adv && (a > 0) && (p == 0);
    if (we) begin
      if (s0 <= 4'd9) m_p0 = s0;
      if (s1 <= 4'd9) m_p1 = s1;
    end
    if (bnd) begin
      m_s0 = m_p0;
      m_s1 = m_p1;
    end
    m_h     = p % HT;
    m_v     = p / HT;
    m_valid = (a > 0) && (m_h < HV) && (m_v < VV);
    m_hs    = !((m_h >= HV + HF) && (m_h < HV + HF + HS));
    m_vs    = !((m_v >= VV + VF) && (m_v < VV + VF + VS));
    m_pe    = adv;
    m_fs    = bnd;
    m_fc    = (a / TOT) % 256;
    #1;
    chk_model();
    bus.score_we = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (n < target) step(1'b0, 4'd0, 4'd0);
  endtask

  // Assert reset off-edge, check outputs drop at once, release off-edge.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals({tag, " async"});
    @(posedge clk);
    #1;
    chk_reset_vals({tag, " held"});
    n = 0;
    m_p0 = 0; m_p1 = 0; m_s0 = 0; m_s1 = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0,   10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{3,   10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{4,   10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{5,   10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{16,  10'd4, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{20,  10'd5, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{24,  10'd6, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{28,  10'd7, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{32,  10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{128, 10'd0, 10'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{160, 10'd0, 10'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{188, 10'd7, 10'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[12] = '{192, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[13] = '{193, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

    rst_n = 1'b0;
    bus.score_we = 1'b0;
    bus.score0_in = 4'd0;
    bus.score1_in = 4'd0;
    m_p0 = 0; m_p1 = 0; m_s0 = 0; m_s1 = 0;
    @(posedge clk);
    do_reset("por");

    // Hand-computed raster checkpoints over the first frame
    foreach (tbl[i]) begin
      run_to(tbl[i].n);
      chk($sformatf("tbl%0d h_cnt", i), 32'(bus.h_cnt), 32'(tbl[i].h));
      chk($sformatf("tbl%0d v_cnt", i), 32'(bus.v_cnt), 32'(tbl[i].v));
      chk($sformatf("tbl%0d valid", i), 32'(bus.valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d hsync", i), 32'(bus.hsync), 32'(tbl[i].hs));
      chk($sformatf("tbl%0d vsync", i), 32'(bus.vsync), 32'(tbl[i].vs));
      chk($sformatf("tbl%0d pix_en", i), 32'(bus.pix_en), 32'(tbl[i].pe));
      chk($sformatf("tbl%0d frame_start", i), 32'(bus.frame_start), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d frame_cnt", i), 32'(bus.frame_cnt), 32'(tbl[i].fc));
    end

    // Mid-frame write of 5/3 stays hidden until the next boundary
    step(1'b1, 4'd5, 4'd3);
    run_to(2 * FRAME_EDGES - 1);
    chk("staged score0 pre", 32'(bus.score0), 0);
    chk("staged score1 pre", 32'(bus.score1), 0);
    step(1'b0, 4'd0, 4'd0);
    chk("staged score0 post", 32'(bus.score0), 5);
    chk("staged score1 post", 32'(bus.score1), 3);
    chk("staged frame_start", 32'(bus.frame_start), 1);

    // Illegal right digit is dropped, left digit still loads
    step(1'b1, 4'd12, 4'd7);
    run_to(3 * FRAME_EDGES);
    chk("illegal score0 kept", 32'(bus.score0), 5);
    chk("legal score1 loaded", 32'(bus.score1), 7);

    // Write on the boundary edge itself bypasses to the outputs
    run_to(4 * FRAME_EDGES - 1);
    step(1'b1, 4'd9, 4'd15);
    chk("bypass frame_start", 32'(bus.frame_start), 1);
    chk("bypass score0", 32'(bus.score0), 9);
    chk("bypass score1 kept", 32'(bus.score1), 7);

    // Random score traffic up to the frame counter wrap
    while (n < 256 * FRAME_EDGES - 1) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    chk("frame_cnt 255", 32'(bus.frame_cnt), 255);
    step(1'b0, 4'd0, 4'd0);
    chk("frame_cnt wrap", 32'(bus.frame_cnt), 0);
    chk("wrap frame_start", 32'(bus.frame_start), 1);

    // Reset in the middle of a frame with a pending 4
    run_to(n + 100);
    step(1'b1, 4'd4, 4'd15);
    step(1'b0, 4'd0, 4'd0);
    do_reset("mid");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd0, 4'd0);
      chk("post-reset h hold", 32'(bus.h_cnt), 0);
      chk("post-reset pix_en low", 32'(bus.pix_en), 0);
    end
    step(1'b0, 4'd0, 4'd0);
    chk("post-reset first h", 32'(bus.h_cnt), 1);
    chk("post-reset first pix_en", 32'(bus.pix_en), 1);
    chk("post-reset first valid", 32'(bus.valid), 1);
    chk("post-reset score0", 32'(bus.score0), 0);
    run_to(FRAME_EDGES);
    chk("post-reset boundary score0", 32'(bus.score0), 0);
    chk("post-reset boundary frame_cnt", 32'(bus.frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing and score-staging stage for the pixel generator.
- Divides the system clock to the 640x480@60 pixel rate and produces registered h_cnt, v_cnt, valid, hsync and vsync.
- Holds the two 4-bit score digits in shadow registers and applies them only at frame boundaries, so the pixel generator never draws a torn digit.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz in, 25 MHz pixel rate).
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync width.
- H_BP, 48: horizontal back porch. H_TOT = 800.
- V_VIS, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync width.
- V_BP, 33: vertical back porch. V_TOT = 525.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- score_we  in  1  single-cycle write strobe for the score inputs.
- score0_in  in  4  right-digit value, legal range 0..9.
- score1_in  in  4  left-digit value, legal range 0..9.
- h_cnt  out  10  current pixel column, 0..H_TOT-1.
- v_cnt  out  10  current line, 0..V_TOT-1.
- valid  out  1  high when h_cnt<H_VIS and v_cnt<V_VIS.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- score0  out  4  frame-stable right digit.
- score1  out  4  frame-stable left digit.
- pix_en  out  1  one-clk pulse marking a new pixel.
- frame_start  out  1  one-clk pulse when counters become (0,0).
- frame_cnt  out  8  frames since reset, wraps.

Behaviour:
- Reset values (async, rst_n=0):
  - div_cnt=0, h_cnt=0, v_cnt=0, valid=0, hsync=1, vsync=1.
  - score0=score1=0, pending regs=0, pix_en=0, frame_start=0, frame_cnt=0.
- Divider: div_cnt counts 0..CLK_DIV-1.
  - On the edge where div_cnt==CLK_DIV-1: div_cnt<=0, an advance occurs, pix_en<=1.
  - On every other edge: pix_en<=0.
  - First advance is on the CLK_DIV-th rising edge after rst_n deasserts.
- Advance:
  - h_cnt<=h_cnt+1, wrapping H_TOT-1 -> 0.
  - On the h wrap, v_cnt<=v_cnt+1, wrapping V_TOT-1 -> 0.
  - Counters hold between advances.
- Derived signals are registered on the same advance edge from the NEW counter values, so they stay aligned with h_cnt and v_cnt:
  - valid = (h<640 && v<480).
  - hsync = 0 iff 656<=h<=751.
  - vsync = 0 iff 490<=v<=491.
  - Consequence: pixel (0,0) of the first frame after reset shows valid=0 (it is the reset state, not an advance). This is accepted behaviour.
- Frame boundary: the advance from (H_TOT-1, V_TOT-1) to (0,0). On that edge:
  - frame_start<=1 for one clk, otherwise 0.
  - frame_cnt<=frame_cnt+1, 8-bit wrap 255 -> 0.
  - score0<=pend0 and score1<=pend1.
- Score staging:
  - When score_we=1, each pending register loads its input only if that input <=9.
  - An input >9 leaves its own pending register unchanged; the other digit still loads if legal.
- score_we coincident with a frame-boundary edge: the legal written value bypasses straight to score0/score1 on that edge and also loads the pending register.
- Scores never change except on a frame-boundary edge.
- Reset mid-frame immediately returns every output to its reset value; counting restarts from (0,0).
- Counter widths: 10 bits covers 799 and 524; there is no other overflow path.

Test Plan:
- Release reset, no writes -> outputs hold reset values for 3 clks; on the 4th edge pix_en=1, h_cnt=1, v_cnt=0, valid=1.
- Run to h_cnt=655, then 656 -> hsync=1 at 655, 0 at 656, still 0 at 751, 1 at 752; valid=0 for h>=640; line wrap 799 -> 0 gives v_cnt+1.
- Run a full frame -> vsync=0 only on lines 490–491; at (799,524) -> (0,0): frame_start high for exactly one clk, frame_cnt 0 -> 1; 256 frames -> frame_cnt wraps to 0.
- score_we with score0_in=5, score1_in=3 mid-frame -> score0/score1 remain 0 until the next frame_start edge, then read 5/3; pulse score0_in=12, score1_in=7 -> after the boundary score0 stays 5, score1 becomes 7.
- score_we with score0_in=9 on the exact frame-boundary edge -> score0=9 in the same cycle frame_start=1.
- Assert rst_n=0 at h=300, v=200 with pend0=4 -> all outputs immediately at reset values; after release, the first advance again lands on the 4th edge with score0=0.
